reset_sequencer: RTL

Multi-channel reset generator, the parametrised successor to the single-output delayed reset pulser. After master reset release it waits DELAY cycles, asserts all NUM_CH reset outputs together for WIDTH cycles, then releases them in staggered order, channel 0 first. Once the sequence completes, each channel can be re-reset on its own, and the whole sequence can be re-run by software. It sits at the top of the monitor design and drives the per-subsystem synchronous resets.

---
 rtl/reset_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Multi-channel reset generator: delayed global assert, staggered release,
// then independent per-channel soft resets and a software re-run of the sequence.
module reset_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int DELAY   = 10,
  parameter int WIDTH   = 20,
  parameter int STAGGER = 3,
  parameter int COUNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reset_all_i,
  input  logic [NUM_CH-1:0] reset_req_i,
  output logic [NUM_CH-1:0] reset_o,
  output logic [NUM_CH-1:0] chan_busy_o,
  output logic              seq_done_o,
  output logic [1:0]        state_dbg_o
);

  typedef enum logic [1:0] {S_DELAY, S_ASSERT, S_RELEASE, S_DONE} state_t;

  localparam logic [COUNT_W-1:0] ASSERT_AT  = COUNT_W'(DELAY);
  localparam logic [COUNT_W-1:0] ASSERT_END = COUNT_W'(DELAY + WIDTH);
  localparam logic [COUNT_W-1:0] SEQ_END    = COUNT_W'(DELAY + WIDTH + (NUM_CH - 1) * STAGGER);
  localparam logic [COUNT_W-1:0] ONE        = COUNT_W'(1);

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  g_cnt_q, g_cnt_d;
  logic [COUNT_W-1:0]  ch_cnt_q [NUM_CH];
  logic [COUNT_W-1:0]  ch_cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   rst_q, rst_d;
  logic [NUM_CH-1:0]   busy_q, busy_d;
  logic                done_q, done_d;

  // Counters hold "edges since trigger": the edge that sees count n is E(n).
  always_comb begin
    state_d  = state_q;
    g_cnt_d  = g_cnt_q;
    rst_d    = rst_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ch_cnt_d = ch_cnt_q;
    unique case (state_q)
      S_DELAY: begin
        g_cnt_d = g_cnt_q + ONE;
        if (g_cnt_q == ASSERT_AT) begin
          rst_d   = '1;
          state_d = S_ASSERT;
        end
      end
      S_ASSERT, S_RELEASE: begin
        g_cnt_d = g_cnt_q + ONE;
        for (int k = 0; k < NUM_CH; k++) begin
          if (g_cnt_q == COUNT_W'(DELAY + WIDTH + k * STAGGER)) rst_d[k] = 1'b0;
        end
        if (g_cnt_q == ASSERT_END) state_d = S_RELEASE;
        // Checked last so a single-edge release (STAGGER=0 or one channel) still finishes.
        if (g_cnt_q == SEQ_END) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          g_cnt_d = g_cnt_q;
        end
      end
      S_DONE: begin
        if (reset_all_i) begin
          // The accepting edge acts as E0, so the next edge must see count 1.
          state_d = S_DELAY;
          g_cnt_d = ONE;
          rst_d   = '0;
          busy_d  = '0;
          done_d  = 1'b0;
          for (int k = 0; k < NUM_CH; k++) ch_cnt_d[k] = '0;
        end else begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (busy_q[k]) begin
              if (ch_cnt_q[k] == ASSERT_END) begin
                busy_d[k]   = 1'b0;
                rst_d[k]    = 1'b0;
                ch_cnt_d[k] = '0;
              end else begin
                ch_cnt_d[k] = ch_cnt_q[k] + ONE;
                if (ch_cnt_q[k] == ASSERT_AT) rst_d[k] = 1'b1;
              end
            end else if (reset_req_i[k]) begin
              busy_d[k]   = 1'b1;
              ch_cnt_d[k] = ONE;
            end
          end
        end
      end
      default: state_d = S_DELAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_DELAY;
      g_cnt_q <= '0;
      rst_q   <= '0;
      busy_q  <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) ch_cnt_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      g_cnt_q  <= g_cnt_d;
      rst_q    <= rst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ch_cnt_q <= ch_cnt_d;
    end
  end

  assign reset_o     = rst_q;
  assign chan_busy_o = busy_q;
  assign seq_done_o  = done_q;
  assign state_dbg_o = state_q;

endmodule
